// File: rtl/cnn_line_buffer_5x5.sv
// cnn_line_buffer_5x5
//   Turns a raster-scan pixel stream into KX x KY sliding windows for a
//   valid (no-padding) convolution. One window is emitted per accepted pixel
//   once the window lies fully inside the image. There is no backpressure.
//
// Ports
//   clk              clock, all logic on the rising edge
//   reset            synchronous, active-high reset
//   i_in_valid       i_in_pixel is valid this cycle (gaps allowed)
//   i_in_pixel       pixel in raster order (row-major)
//   o_ot_valid       o_ot_window valid, one cycle per window
//   o_ot_window      packed window, element r*KX+c at [(r*KX+c)*I_F_BW +: I_F_BW]
//                    r=0 oldest row, c=0 oldest column
//   o_ot_frame_done  one-cycle pulse after the last pixel of a frame is accepted
module cnn_line_buffer_5x5 #(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned KX     = 5,
  parameter int unsigned KY     = 5,
  parameter int unsigned I_F_BW = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_in_valid,
  input  logic [I_F_BW-1:0]          i_in_pixel,
  output logic                       o_ot_valid,
  output logic [KX*KY*I_F_BW-1:0]    o_ot_window,
  output logic                       o_ot_frame_done
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);
  localparam logic [CW-1:0] ColWin  = CW'(KX - 1);
  localparam logic [RW-1:0] RowWin  = RW'(KY - 1);

  // lb_q[0] holds the previous line, lb_q[KY-2] the oldest one.
  logic [I_F_BW-1:0]       lb_q [KY-1][IMG_W];

  logic [CW-1:0]           col_q;
  logic [RW-1:0]           row_q;
  logic [KX*KY*I_F_BW-1:0] window_q, window_d;
  logic                    valid_q;
  logic                    frame_done_q;

  logic [I_F_BW-1:0]       new_col [KY];
  logic                    col_last, row_last, in_window;

  assign col_last  = (col_q == ColLast);
  assign row_last  = (row_q == RowLast);
  assign in_window = (col_q >= ColWin) && (row_q >= RowWin);

  // Column entering the window: oldest line on top, live pixel at the bottom.
  always_comb begin
    new_col[KY-1] = i_in_pixel;
    for (int r = 0; r < int'(KY) - 1; r++) begin
      new_col[r] = lb_q[int'(KY) - 2 - r][col_q];
    end
  end

  // Shift every row one column towards c=0 and insert the new column at c=KX-1.
  always_comb begin
    window_d = window_q;
    for (int r = 0; r < int'(KY); r++) begin
      for (int c = 0; c < int'(KX); c++) begin
        if (c < int'(KX) - 1) begin
          window_d[(r*KX + c)*I_F_BW +: I_F_BW] = window_q[(r*KX + c + 1)*I_F_BW +: I_F_BW];
        end else begin
          window_d[(r*KX + c)*I_F_BW +: I_F_BW] = new_col[r];
        end
      end
    end
  end

  // Line memories carry no reset; their contents are never emitted before
  // KY-1 full lines of the current frame have overwritten them.
  always_ff @(posedge clk) begin
    if (!reset && i_in_valid) begin
      lb_q[0][col_q] <= i_in_pixel;
      for (int k = 1; k < int'(KY) - 1; k++) begin
        lb_q[k][col_q] <= lb_q[k-1][col_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      window_q     <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (i_in_valid) begin
        window_q     <= window_d;
        valid_q      <= in_window;
        frame_done_q <= col_last && row_last;
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  assign o_ot_valid      = valid_q;
  assign o_ot_window     = window_q;
  assign o_ot_frame_done = frame_done_q;

endmodule
